pps_phase_meas_n: RTL and testbench
===================================

// Module: pps_phase_meas_n
// PURPOSE
//  N-channel PPS phase meter, successor to the fixed 4-input phase path. Timestamps rising edges of
//  NCH PPS inputs against one free-running counter and reports each channel's signed offset from
//  channel 0 (reference, GPS 1PPS) once per epoch. Results stream out over valid/ready to the UART
//  answer formatter. Sits in the 100 MHz ref-clock domain.
// PARAMETERS
//  NCH       4            channel count (2..16); ch0 = reference
//  CNT_W     28           timestamp/phase width; 2^CNT_W > one PPS period in ticks
//  WIN_TICKS 50_000_000   ticks from ref edge to epoch close (half period)
//  REF_TO    150_000_000  ticks without ref edge before o_ref_lost asserts
//  SYNC_STG  2            input synchroniser depth (>=2)
// PORTS
//  i_clk      in   1          sample/timebase clock
//  i_rst      in   1          asynchronous reset, active-high
//  i_pps      in   NCH        raw PPS inputs, async to i_clk
//  o_valid    out  1          record valid
//  i_ready    in   1          record accepted when o_valid & i_ready
//  o_ch       out  CH_W       channel index of record, CH_W = clog2(NCH)
//  o_phase    out  CNT_W      signed ts_ch - ts_0 (or period, see CONFIGURATION)
//  o_miss     out  1          channel had no edge this epoch; o_phase = 0
//  o_dup      out  1          channel had >1 edge this epoch; last edge used
//  o_last     out  1          final record of epoch
//  o_ref_lost out  1          level: no ref edge for REF_TO ticks
//  o_drop_cnt out  8          epochs dropped due to backpressure, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, counter 0, fresh/dup flags clear, state IDLE.
//  - Timebase cnt free-runs mod 2^CNT_W. Each input: SYNC_STG-FF sync + rise detect; ts_k latched on
//    detect cycle (fixed latency SYNC_STG+1, identical per channel, cancels in phase).
//  - Edge on ch k>0 at any time: ts_k <= cnt; if fresh_k already set, dup_k <= 1; fresh_k <= 1.
//  - FSM IDLE: wait ref edge -> ts_0 <= cnt, win <= 0, WAIT.
//  - WAIT: win++; ref edge again -> ts_0 updated, win restarts. win == WIN_TICKS-1 -> snapshot
//    fresh/dup/ts into output bank, clear fresh/dup (edge on same cycle lands in next epoch), EMIT.
//  - EMIT: present records ch 1..NCH-1 ascending; advance only on o_valid & i_ready; o_valid held,
//    outputs stable while stalled. o_last on ch NCH-1. After last accept -> IDLE (or WAIT if a ref
//    edge was latched during EMIT; ts_0 of that edge kept).
//  - Phase = (ts_k - ts_0) mod 2^CNT_W read as two's complement: leads negative, lags positive.
//  - Epoch close while previous EMIT still pending: new epoch discarded, o_drop_cnt++ (sat 255),
//    fresh flags still cleared.
//  - o_ref_lost: set when ticks since last ref edge reach REF_TO; cleared on next ref edge. No
//    records while lost.
//  - Reset mid-EMIT: record aborted, o_valid drops asynchronously.
// CONFIGURATION
//  PPS_PERIOD_EN defined: EMIT first emits an o_ch = 0 record, o_phase = unsigned ts_0 - ts_0_prev
//    (ref period in ticks, frequency of i_clk vs GPS); o_miss = 1 on first epoch after reset or
//    after ref_lost. Records per epoch = NCH.
//  Undefined: no ch0 record; records per epoch = NCH-1; ts_0_prev register absent.
// STRUCTURE
//  Shared include pps_meas_pkg.vh: FSM state encodings (IDLE/WAIT/EMIT), clog2 function, record
//  field widths. Sub-module pps_edge_sync (SYNC_STG sync + rising-edge pulse), one per channel.
// TESTING
//  1. NCH=4; PPS0 rise at t, PPS1 t+100, PPS2 t-250, PPS3 absent -> records ch1 +100, ch2 -250,
//     ch3 miss=1 phase 0, o_last on ch3.
//  2. Hold i_ready=0 for 1000 cycles in EMIT -> o_valid, o_ch, o_phase stable; then 3 accepts.
//  3. Keep i_ready=0 across two epoch closes -> o_drop_cnt = 1, next epoch data correct.
//  4. Two PPS1 edges in one epoch at +10 and +40 -> ch1 phase +40, o_dup=1.
//  5. Stop PPS0 -> o_ref_lost=1 REF_TO ticks after last edge; restart -> clears, records resume.
//  6. PPS_PERIOD_EN, PPS0 every 100_000_003 ticks -> ch0 record o_phase = 100_000_003, first miss=1.

Source files
------------

// File: rtl/pps_phase_meas_n_pkg.sv
// Shared FSM encoding and sizing helpers for the N-channel PPS phase meter.
package pps_phase_meas_n_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } state_t;

  localparam int DROP_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pps_phase_meas_n_edge_sync.sv
// Multi-stage synchroniser plus rising-edge pulse for one PPS input.
module pps_edge_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pps,
  output logic o_rise
);

  logic [SYNC_STG-1:0] sr;
  logic                dly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr  <= '0;
      dly <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STG-2:0], i_pps};
      dly <= sr[SYNC_STG-1];
    end
  end

  assign o_rise = sr[SYNC_STG-1] & ~dly;

endmodule

// File: rtl/pps_phase_meas_n.sv
// N-channel PPS phase meter: per-epoch offsets of ch1..N-1 against ch0.
// Define PPS_PERIOD_EN to add a ch0 record carrying the reference period.
module pps_phase_meas_n
  import pps_phase_meas_n_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CNT_W     = 28,
  parameter int WIN_TICKS = 50_000_000,
  parameter int REF_TO    = 150_000_000,
  parameter int SYNC_STG  = 2,
  localparam int CH_W     = clog2(NCH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_pps,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CH_W-1:0]   o_ch,
  output logic [CNT_W-1:0]  o_phase,
  output logic              o_miss,
  output logic              o_dup,
  output logic              o_last,
  output logic              o_ref_lost,
  output logic [DROP_W-1:0] o_drop_cnt
);

`ifdef PPS_PERIOD_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int NREC  = NCH - 1 + OFS;
  localparam int WIN_W = clog2(WIN_TICKS);
  localparam int TO_W  = clog2(REF_TO + 1);

  state_t state, state_n;
  logic armed, armed_n;
  logic [NCH-1:0] rise;
  logic [CNT_W-1:0] cnt, ts0;
  logic [CNT_W-1:0] ts [1:NCH-1];
  logic [NCH-1:1] fresh, dup;
  logic [WIN_W-1:0] win;
  logic [TO_W-1:0] since;
  logic lost;
  logic [DROP_W-1:0] drop_cnt;
  logic [CH_W-1:0] idx;
  logic [CNT_W-1:0] b_phase [NREC];
  logic [NREC-1:0] b_miss, b_dup;
  logic ref_e, counting, close, snap, drop;
  logic accept, fin, to_hit;

  for (genvar k = 0; k < NCH; k++) begin : g_sync
    pps_edge_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_pps (i_pps[k]),
      .o_rise(rise[k])
    );
  end

  // Window also runs in EMIT once a new ref edge arrived, so a
  // second close while stalled is seen and counted as a drop.
  assign ref_e    = rise[0];
  assign counting = (state == WAIT) || (state == EMIT && armed);
  assign close    = counting && !ref_e &&
                    (win == WIN_W'(WIN_TICKS - 1));
  assign snap     = close && (state == WAIT);
  assign drop     = close && (state == EMIT);
  assign accept   = (state == EMIT) && i_ready;
  assign fin      = accept && (idx == CH_W'(NREC - 1));
  assign to_hit   = !ref_e && (since == TO_W'(REF_TO - 1));

  always_comb begin
    state_n = state;
    armed_n = armed;
    unique case (state)
      IDLE: if (ref_e) state_n = WAIT;
      WAIT: if (snap) state_n = EMIT;
      EMIT: begin
        if (ref_e) armed_n = 1'b1;
        else if (drop) armed_n = 1'b0;
        if (fin) begin
          state_n = armed_n ? WAIT : IDLE;
          armed_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      armed    <= 1'b0;
      cnt      <= '0;
      ts0      <= '0;
      win      <= '0;
      since    <= '0;
      lost     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      armed <= armed_n;
      cnt   <= cnt + CNT_W'(1);
      if (ref_e) begin
        ts0 <= cnt;
        win <= '0;
      end else if (counting) begin
        win <= win + WIN_W'(1);
      end
      if (ref_e) begin
        since <= '0;
        lost  <= 1'b0;
      end else if (since != TO_W'(REF_TO)) begin
        since <= since + TO_W'(1);
        if (to_hit) lost <= 1'b1;
      end
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // An edge on the closing cycle belongs to the next epoch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fresh <= '0;
      dup   <= '0;
      for (int k = 1; k < NCH; k++) ts[k] <= '0;
    end else begin
      for (int k = 1; k < NCH; k++) begin
        if (rise[k]) ts[k] <= cnt;
        if (close) begin
          fresh[k] <= rise[k];
          dup[k]   <= 1'b0;
        end else if (rise[k]) begin
          fresh[k] <= 1'b1;
          dup[k]   <= dup[k] | fresh[k];
        end
      end
    end
  end

`ifdef PPS_PERIOD_EN
  logic [CNT_W-1:0] ts0_prev;
  logic prev_ok;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ts0_prev <= '0;
      prev_ok  <= 1'b0;
    end else begin
      if (close) begin
        ts0_prev <= ts0;
        prev_ok  <= 1'b1;
      end
      if (to_hit) prev_ok <= 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx    <= '0;
      b_miss <= '0;
      b_dup  <= '0;
      for (int r = 0; r < NREC; r++) b_phase[r] <= '0;
    end else if (snap) begin
      idx <= '0;
      for (int k = 1; k < NCH; k++) begin
        b_phase[k-1+OFS] <= fresh[k] ? ts[k] - ts0 : '0;
        b_miss[k-1+OFS]  <= ~fresh[k];
        b_dup[k-1+OFS]   <= dup[k];
      end
`ifdef PPS_PERIOD_EN
      b_phase[0] <= prev_ok ? ts0 - ts0_prev : '0;
      b_miss[0]  <= ~prev_ok;
      b_dup[0]   <= 1'b0;
`endif
    end else if (accept) begin
      idx <= fin ? '0 : idx + CH_W'(1);
    end
  end

  assign o_valid    = (state == EMIT);
  assign o_ch       = o_valid ? idx + CH_W'(1 - OFS) : '0;
  assign o_phase    = o_valid ? b_phase[idx] : '0;
  assign o_miss     = o_valid & b_miss[idx];
  assign o_dup      = o_valid & b_dup[idx];
  assign o_last     = o_valid && (idx == CH_W'(NREC - 1));
  assign o_ref_lost = lost;
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_pps_phase_meas_n.sv
// Directed + randomized bench for pps_phase_meas_n against an event-list model.
module tb_pps_phase_meas_n;

  localparam int NCH    = 4;
  localparam int CNT_W  = 16;
  localparam int WIN    = 400;
  localparam int REF_TO = 3000;
  localparam int SYNC   = 2;
  localparam int PW     = 8;
`ifdef PPS_PERIOD_EN
  localparam int NREC = NCH;
`else
  localparam int NREC = NCH - 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   pps;
  logic             rdy;
  logic             o_valid, o_miss, o_dup, o_last, o_ref_lost;
  logic [1:0]       o_ch;
  logic [CNT_W-1:0] o_phase;
  logic [7:0]       o_drop_cnt;

  always #5 clk = ~clk;

  pps_phase_meas_n #(
    .NCH(NCH), .CNT_W(CNT_W), .WIN_TICKS(WIN),
    .REF_TO(REF_TO), .SYNC_STG(SYNC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pps(pps),
    .o_valid(o_valid), .i_ready(rdy), .o_ch(o_ch),
    .o_phase(o_phase), .o_miss(o_miss), .o_dup(o_dup),
    .o_last(o_last), .o_ref_lost(o_ref_lost),
    .o_drop_cnt(o_drop_cnt)
  );

  typedef struct {
    int ch;
    int t;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  int          e_ch [NREC];
  logic [15:0] e_ph [NREC];
  logic        e_miss [NREC];
  logic        e_dup [NREC];
`ifdef PPS_PERIOD_EN
  int prev_r = -1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] v;
    @(negedge clk);
    cyc++;
    v = '0;
    foreach (evq[i])
      if (cyc >= evq[i].t && cyc < evq[i].t + PW) v[evq[i].ch] = 1'b1;
    pps = v;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic ev(input int ch, input int t);
    evq.push_back('{ch, t});
  endtask

  // Expected records: last edge per channel inside (lo, r+WIN].
  task automatic build(input int r, input int lo);
    int n;
    n = 0;
`ifdef PPS_PERIOD_EN
    e_ch[0]   = 0;
    e_miss[0] = (prev_r < 0);
    e_ph[0]   = (prev_r < 0) ? 16'd0 : 16'(r - prev_r);
    e_dup[0]  = 1'b0;
    prev_r    = r;
    n = 1;
`endif
    for (int k = 1; k < NCH; k++) begin
      int c, last;
      c = 0;
      last = 0;
      foreach (evq[i])
        if (evq[i].ch == k && evq[i].t > lo && evq[i].t <= r + WIN) begin
          c++;
          if (evq[i].t > last) last = evq[i].t;
        end
      e_ch[n]   = k;
      e_miss[n] = (c == 0);
      e_dup[n]  = (c > 1);
      e_ph[n]   = (c == 0) ? 16'd0 : 16'(last - r);
      n++;
    end
  endtask

  task automatic collect(input bit rnd);
    int n, w;
    bit a;
    n = 0;
    w = 0;
    while (n < NREC && w < 3000) begin
      tick();
      w++;
      a = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = a;
      if (o_valid && a) begin
        chk($sformatf("ch[%0d]", n), o_ch, e_ch[n]);
        chk($sformatf("phase[ch%0d]", e_ch[n]), o_phase, e_ph[n]);
        chk($sformatf("miss[ch%0d]", e_ch[n]), o_miss, e_miss[n]);
        chk($sformatf("dup[ch%0d]", e_ch[n]), o_dup, e_dup[n]);
        chk($sformatf("last[ch%0d]", e_ch[n]), o_last, n == NREC - 1);
        n++;
      end
    end
    chk("rec_count", n, NREC);
    tick();
    rdy = 1'b0;
  endtask

  task automatic wait_valid(input int lim);
    int w;
    w = 0;
    while (!o_valid && w < lim) begin
      tick();
      w++;
    end
    chk("valid_seen", o_valid, 1);
  endtask

  task automatic rnd_epoch(input int r);
    ev(0, r);
    for (int k = 1; k < NCH; k++) begin
      int m, a;
      m = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 800)) - 500;
      if (m != 0) ev(k, r + a);
      if (m == 3) ev(k, r + a + int'($urandom_range(12, 40)));
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    pps = '0;
    rdy = 1'b0;
    repeat (4) tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_phase", o_phase, 0);
    chk("rst_miss", o_miss, 0);
    chk("rst_last", o_last, 0);
    chk("rst_lost", o_ref_lost, 0);
    chk("rst_drop", o_drop_cnt, 0);
    rst = 1'b0;

    // lead/lag/miss, held stalled for 1000 cycles
    ev(2, 750);
    ev(0, 1000);
    ev(1, 1100);
    build(1000, 0);
    wait_valid(2000);
    bad = 0;
    repeat (1000) begin
      tick();
      if (o_valid !== 1'b1 || o_ch !== 2'(e_ch[0]) || o_phase !== e_ph[0])
        bad++;
    end
    chk("stall_stable", bad, 0);
    collect(1'b0);

    // duplicate edges, then a second close while stalled
    ev(2, 2900);
    ev(0, 3000);
    ev(1, 3010);
    ev(1, 3040);
    ev(3, 3200);
    build(3000, 1400);
    ev(0, 4000);
    ev(1, 4005);
    ev(3, 4100);
`ifdef PPS_PERIOD_EN
    prev_r = 4000;
`endif
    run_to(4600);
    chk("drop_cnt", o_drop_cnt, 1);
    collect(1'b0);

    ev(2, 4980);
    ev(0, 5000);
    ev(1, 5020);
    build(5000, 4400);
    collect(1'b0);
    chk("drop_kept", o_drop_cnt, 1);

    // reference loss and recovery
    run_to(7950);
    chk("lost_early", o_ref_lost, 0);
    run_to(8060);
    chk("lost_set", o_ref_lost, 1);
    chk("lost_novalid", o_valid, 0);
`ifdef PPS_PERIOD_EN
    prev_r = -1;
`endif
    ev(2, 8970);
    ev(0, 9000);
    ev(1, 9050);
    run_to(9020);
    chk("lost_clear", o_ref_lost, 0);
    build(9000, 5400);
    collect(1'b0);

    for (int i = 0; i < 3; i++) begin
      int r;
      r = 10000 + 1000 * i;
      rnd_epoch(r);
      build(r, r - 600);
      collect(1'b1);
    end

    // asynchronous reset while a record is pending
    rnd_epoch(13000);
    wait_valid(2000);
    rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_drop", o_drop_cnt, 0);
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
